fetch_id_alloc: RTL and testbench
=================================

// Module: fetch_id_alloc
// PURPOSE
//   Allocates fetch IDs for fetched instruction packets and drives the single write port of the PC file.
//   A circular buffer over 2**ADDR_SIZE IDs: allocate at head, free at commit (tail), roll head back on flush.
//   Sits between the fetch/PC-gen stage and the PC file; the returned fetch ID travels with the packet and later reads its PC back.
// PARAMETERS
//   WORD_SIZE  31  stored PC width (byte PC[31:1]); matches the PC file word
//   ADDR_SIZE  5   fetch-ID width; number of IDs is 2**ADDR_SIZE
// PORTS
//   clk             in   1          clock, all state on posedge
//   rst_n           in   1          asynchronous, active-low reset
//   IN_valid        in   1          fetch requests an ID for IN_pc
//   IN_pc           in   WORD_SIZE  PC to record
//   OUT_ready       out  1          an ID is free (count < 2**ADDR_SIZE)
//   OUT_fetchID     out  ADDR_SIZE  ID granted this cycle (= head[ADDR_SIZE-1:0])
//   OUT_pcWen       out  1          PC file write enable (registered)
//   OUT_pcWaddr     out  ADDR_SIZE  PC file write address (registered)
//   OUT_pcWdata     out  WORD_SIZE  PC file write data (registered)
//   IN_commitValid  in   1          entries up to and including IN_commitID retire
//   IN_commitID     in   ADDR_SIZE  youngest retiring ID
//   IN_flush        in   1          mispredict: discard all IDs younger than IN_flushID
//   IN_flushID      in   ADDR_SIZE  youngest surviving ID
//   OUT_count       out  ADDR_SIZE+1  IDs currently allocated, 0..2**ADDR_SIZE
//   OUT_err         out  1          sticky: commit/flush named an unallocated ID
// BEHAVIOUR
//   - State: head, tail are ADDR_SIZE+1-bit pointers (extra wrap bit); count = head - tail; full = count == 2**ADDR_SIZE.
//   - Reset (async, rst_n low): head = tail = 0, OUT_pcWen = 0, OUT_pcWaddr = 0, OUT_pcWdata = 0, OUT_err = 0.
//     Hence OUT_ready = 1, OUT_fetchID = 0, OUT_count = 0. A pending write is dropped when reset asserts mid-operation.
//   - Allocation fires when IN_valid && OUT_ready && !IN_flush. The fire:
//     - grants OUT_fetchID in the same cycle and increments head;
//     - sets OUT_pcWen = 1, OUT_pcWaddr = old head, OUT_pcWdata = IN_pc on the next cycle.
//     The PC is therefore readable from the PC file 2 cycles after the grant. OUT_ready depends on state only.
//   - Allocation in a flush cycle is squashed: no head increment, no write. Fetch is being redirected.
//   - Commit, with d = (IN_commitID - tail[ADDR_SIZE-1:0]) mod 2**ADDR_SIZE:
//     - if d < count: tail += d + 1;
//     - otherwise: ignore and set OUT_err.
//   - Flush, with f = (IN_flushID - tail[ADDR_SIZE-1:0]) mod 2**ADDR_SIZE:
//     - if f < count: head = tail + f + 1;
//     - otherwise: ignore and set OUT_err.
//   - Simultaneous commit + flush: both are evaluated against pre-edge tail/count. Then new tail = commit result, new head = flush result.
//     If the commit retires past the flush point, new head = new tail (empty).
//   - Commit + allocate in the same cycle: both apply; count = count - (d+1) + 1. Allocation uses the pre-edge full.
//   - Wrap-around: pointers are modular over 2**(ADDR_SIZE+1), and the IDs seen by the PC file wrap at 2**ADDR_SIZE.
//   - Full: OUT_ready = 0 and IN_valid is ignored (no error).
//   - An already-registered write to an ID later discarded by a flush still completes. This is harmless: the ID is re-allocated and rewritten.
//   - OUT_err clears only on reset.
// STRUCTURE
//   - Shared package pc_alloc_pkg:
//     - typedef FetchID_t (ADDR_SIZE bits) and FetchPtr_t (ADDR_SIZE+1 bits);
//     - constants NUM_FETCH_IDS, FETCH_ID_BITS;
//     - function id_dist(id, ptr) returning the modular distance.
//   - Single flat module: head/tail registers, one write-stage register set, error flag. No sub-module is warranted.
// TESTING
//   1. Reset, then IN_valid with IN_pc=0x0000_1000 for 3 cycles -> IDs 0,1,2 granted.
//      OUT_pcWen on cycles 1-3 with addr 0,1,2; OUT_count=3.
//   2. Allocate 32 with no commit -> OUT_ready=0 at count=32, further IN_valid ignored.
//      Then commit ID 4 -> OUT_count=27, OUT_ready=1 next cycle.
//   3. Wrap: drive 40 alloc/commit pairs -> the grant after ID 31 is 0, count stays 1, OUT_err=0.
//   4. IDs 0..9 allocated, IN_flush ID 5 with IN_valid high -> no grant/write that cycle.
//      Next grant is ID 6, OUT_count=6.
//   5. IDs 0..9 allocated; same cycle commit ID 7 + flush ID 3 -> tail=head=8, OUT_count=0.
//   6. Count=2 (IDs 0,1), commit ID 9 -> ignored, OUT_err=1.
//      Assert rst_n low mid-write -> OUT_pcWen=0 immediately, OUT_err=0.

Source files
------------

// File: rtl/pc_alloc_pkg.sv
// Shared definitions for fetch-ID allocation.
//   FetchID_t     : fetch ID as seen by the PC file (wraps at NUM_FETCH_IDS)
//   FetchPtr_t    : head/tail pointer, one extra wrap bit to tell full from empty
//   id_dist       : modular distance from a pointer's ID to a given ID
package pc_alloc_pkg;

  localparam int FETCH_ID_BITS = 5;
  localparam int NUM_FETCH_IDS = 2 ** FETCH_ID_BITS;

  typedef logic [FETCH_ID_BITS-1:0] FetchID_t;
  typedef logic [FETCH_ID_BITS:0]   FetchPtr_t;

  // Distance (mod NUM_FETCH_IDS) from the ID addressed by ptr forward to id.
  function automatic FetchID_t id_dist(input FetchID_t id, input FetchPtr_t ptr);
    return FetchID_t'(id - ptr[FETCH_ID_BITS-1:0]);
  endfunction

endpackage

// File: rtl/fetch_id_alloc.sv
// Fetch-ID allocator and PC-file write port driver.
// Circular buffer over 2**ADDR_SIZE IDs: allocate at head, retire at tail on
// commit, roll head back on flush.
//   clk, rst_n         clock / async active-low reset
//   IN_valid, IN_pc    fetch asks for an ID to record IN_pc
//   OUT_ready          an ID is free
//   OUT_fetchID        ID granted this cycle
//   OUT_pcWen/Waddr/Wdata  registered PC-file write
//   IN_commitValid/ID  retire up to and including IN_commitID
//   IN_flush/ID        drop everything younger than IN_flushID
//   OUT_count          IDs allocated (0..2**ADDR_SIZE)
//   OUT_err            sticky: commit/flush named an unallocated ID
module fetch_id_alloc
  import pc_alloc_pkg::*;
#(
  parameter int WORD_SIZE = 31,
  parameter int ADDR_SIZE = FETCH_ID_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 IN_valid,
  input  logic [WORD_SIZE-1:0] IN_pc,
  output logic                 OUT_ready,
  output logic [ADDR_SIZE-1:0] OUT_fetchID,
  output logic                 OUT_pcWen,
  output logic [ADDR_SIZE-1:0] OUT_pcWaddr,
  output logic [WORD_SIZE-1:0] OUT_pcWdata,
  input  logic                 IN_commitValid,
  input  logic [ADDR_SIZE-1:0] IN_commitID,
  input  logic                 IN_flush,
  input  logic [ADDR_SIZE-1:0] IN_flushID,
  output logic [ADDR_SIZE:0]   OUT_count,
  output logic                 OUT_err
);

  localparam logic [ADDR_SIZE:0] PTR_ONE = (ADDR_SIZE+1)'(1);

  logic [ADDR_SIZE:0]   head, tail;
  logic [ADDR_SIZE:0]   head_nxt, tail_nxt;
  logic [ADDR_SIZE:0]   count;
  logic [ADDR_SIZE-1:0] d_commit, d_flush;
  logic                 fire, commit_ok, flush_ok, bad_req;

  assign count       = head - tail;
  // Only count == 2**ADDR_SIZE has the top bit set.
  assign OUT_ready   = ~count[ADDR_SIZE];
  assign OUT_fetchID = head[ADDR_SIZE-1:0];
  assign OUT_count   = count;

  assign fire      = IN_valid && OUT_ready && !IN_flush;
  assign d_commit  = id_dist(IN_commitID, tail);
  assign d_flush   = id_dist(IN_flushID, tail);
  assign commit_ok = IN_commitValid && ({1'b0, d_commit} < count);
  assign flush_ok  = IN_flush && ({1'b0, d_flush} < count);
  assign bad_req   = (IN_commitValid && !commit_ok) || (IN_flush && !flush_ok);

  always_comb begin
    tail_nxt = tail;
    head_nxt = head;
    if (commit_ok)
      tail_nxt = tail + {1'b0, d_commit} + PTR_ONE;
    if (flush_ok) begin
      // A commit that reaches the flush point leaves the buffer empty.
      if (commit_ok && (d_commit >= d_flush))
        head_nxt = tail_nxt;
      else
        head_nxt = tail + {1'b0, d_flush} + PTR_ONE;
    end else if (fire) begin
      head_nxt = head + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head        <= '0;
      tail        <= '0;
      OUT_pcWen   <= 1'b0;
      OUT_pcWaddr <= '0;
      OUT_pcWdata <= '0;
      OUT_err     <= 1'b0;
    end else begin
      head      <= head_nxt;
      tail      <= tail_nxt;
      OUT_pcWen <= fire;
      if (fire) begin
        OUT_pcWaddr <= head[ADDR_SIZE-1:0];
        OUT_pcWdata <= IN_pc;
      end
      if (bad_req)
        OUT_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_id_alloc.sv
module tb_fetch_id_alloc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        IN_valid = 1'b0;
  logic [30:0] IN_pc = '0;
  logic        OUT_ready;
  logic [4:0]  OUT_fetchID;
  logic        OUT_pcWen;
  logic [4:0]  OUT_pcWaddr;
  logic [30:0] OUT_pcWdata;
  logic        IN_commitValid = 1'b0;
  logic [4:0]  IN_commitID = '0;
  logic        IN_flush = 1'b0;
  logic [4:0]  IN_flushID = '0;
  logic [5:0]  OUT_count;
  logic        OUT_err;

  int checks = 0;
  int errors = 0;

  fetch_id_alloc dut (
    .clk(clk), .rst_n(rst_n),
    .IN_valid(IN_valid), .IN_pc(IN_pc),
    .OUT_ready(OUT_ready), .OUT_fetchID(OUT_fetchID),
    .OUT_pcWen(OUT_pcWen), .OUT_pcWaddr(OUT_pcWaddr), .OUT_pcWdata(OUT_pcWdata),
    .IN_commitValid(IN_commitValid), .IN_commitID(IN_commitID),
    .IN_flush(IN_flush), .IN_flushID(IN_flushID),
    .OUT_count(OUT_count), .OUT_err(OUT_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: unbounded allocation/retirement counters; IDs are those mod 32.
  int    m_alloc = 0;
  int    m_retire = 0;
  bit    m_err = 0;
  bit    e_wen = 0;
  int    e_waddr = 0;
  logic [30:0] e_wdata = '0;
  int    mc, mna, mnr, md, mf;
  bit    mfire;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_alloc = 0; m_retire = 0; m_err = 0; e_wen = 0; e_waddr = 0; e_wdata = '0;
    end else begin
      mc  = m_alloc - m_retire;
      mna = m_alloc;
      mnr = m_retire;
      mfire = IN_valid && (mc < 32) && !IN_flush;
      e_wen = mfire;
      if (mfire) begin
        e_waddr = m_alloc % 32;
        e_wdata = IN_pc;
        mna = m_alloc + 1;
      end
      if (IN_commitValid) begin
        md = (int'(IN_commitID) - (m_retire % 32) + 32) % 32;
        if (md < mc) mnr = m_retire + md + 1;
        else m_err = 1;
      end
      if (IN_flush) begin
        mf = (int'(IN_flushID) - (m_retire % 32) + 32) % 32;
        if (mf < mc) mna = m_retire + mf + 1;
        else m_err = 1;
      end
      if (mna < mnr) mna = mnr;
      m_alloc = mna;
      m_retire = mnr;
    end
  end

  always @(negedge clk) begin
    chk("ready",   OUT_ready, (m_alloc - m_retire) < 32);
    chk("fetchID", OUT_fetchID, m_alloc % 32);
    chk("count",   OUT_count, m_alloc - m_retire);
    chk("err",     OUT_err, m_err);
    chk("pcWen",   OUT_pcWen, e_wen);
    if (e_wen) begin
      chk("pcWaddr", OUT_pcWaddr, e_waddr);
      chk("pcWdata", OUT_pcWdata, e_wdata);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    IN_valid = 0; IN_commitValid = 0; IN_flush = 0;
    IN_commitID = '0; IN_flushID = '0; IN_pc = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    step();
    @(negedge clk);
    rst_n = 1;
    step();
  endtask

  task automatic alloc_n(input int n);
    IN_valid = 1;
    for (int i = 0; i < n; i++) begin
      IN_pc = 31'h2000 + 31'(i);
      step();
    end
    IN_valid = 0;
  endtask

  initial begin
    do_reset();
    // 1: three grants
    chk("t1_reset_count", OUT_count, 0);
    chk("t1_reset_ready", OUT_ready, 1);
    IN_valid = 1; IN_pc = 31'h1000;
    chk("t1_id0", OUT_fetchID, 0);
    step();
    chk("t1_id1", OUT_fetchID, 1);
    chk("t1_wen0", OUT_pcWen, 1);
    chk("t1_waddr0", OUT_pcWaddr, 0);
    step();
    chk("t1_id2", OUT_fetchID, 2);
    chk("t1_waddr1", OUT_pcWaddr, 1);
    step();
    IN_valid = 0;
    chk("t1_waddr2", OUT_pcWaddr, 2);
    chk("t1_wdata2", OUT_pcWdata, 31'h1000);
    chk("t1_count", OUT_count, 3);
    // 2: fill, overfill, commit 4
    alloc_n(31);
    chk("t2_count_full", OUT_count, 32);
    chk("t2_ready_full", OUT_ready, 0);
    chk("t2_model_full", m_alloc - m_retire, 32);
    IN_commitValid = 1; IN_commitID = 5'd4;
    step();
    IN_commitValid = 0;
    chk("t2_count_commit", OUT_count, 27);
    chk("t2_ready_commit", OUT_ready, 1);
    chk("t2_model_commit", m_alloc - m_retire, 27);
    // 3: wrap with alloc/commit pairs
    do_reset();
    alloc_n(1);
    for (int i = 0; i < 40; i++) begin
      IN_valid = 1; IN_pc = 31'h3000 + 31'(i);
      IN_commitValid = 1; IN_commitID = 5'(i % 32);
      if (i == 31) chk("t3_wrap_id", OUT_fetchID, 0);
      step();
    end
    clear_inputs();
    chk("t3_count", OUT_count, 1);
    chk("t3_err", OUT_err, 0);
    // 4: flush squashes allocation
    do_reset();
    alloc_n(10);
    chk("t4_count10", OUT_count, 10);
    IN_valid = 1; IN_pc = 31'h4444; IN_flush = 1; IN_flushID = 5'd5;
    step();
    clear_inputs();
    chk("t4_no_write", OUT_pcWen, 0);
    chk("t4_count", OUT_count, 6);
    chk("t4_next_id", OUT_fetchID, 6);
    // 5: commit past the flush point empties the buffer
    do_reset();
    alloc_n(10);
    IN_commitValid = 1; IN_commitID = 5'd7; IN_flush = 1; IN_flushID = 5'd3;
    step();
    clear_inputs();
    chk("t5_count", OUT_count, 0);
    chk("t5_next_id", OUT_fetchID, 8);
    chk("t5_err", OUT_err, 0);
    // 6: bad commit, then reset mid-write
    do_reset();
    alloc_n(2);
    IN_commitValid = 1; IN_commitID = 5'd9;
    step();
    clear_inputs();
    chk("t6_err", OUT_err, 1);
    chk("t6_count", OUT_count, 2);
    IN_valid = 1; IN_pc = 31'h5555;
    step();
    IN_valid = 0;
    chk("t6_wen_before", OUT_pcWen, 1);
    #2;
    rst_n = 0;
    #1;
    chk("t6_wen_reset", OUT_pcWen, 0);
    chk("t6_err_reset", OUT_err, 0);
    chk("t6_count_reset", OUT_count, 0);
    @(negedge clk);
    rst_n = 1;
    step();
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
